sprite_fetch_arbiter: RTL and testbench

// - Shares the single-port, 1-cycle-latency sprite ROM (12 pieces + 10 digits, 60x60x24b)

---
 rtl/sprite_fetch_arbiter_pkg.sv | 56 +++++
 rtl/sprite_addr_calc.sv | 45 ++++
 rtl/sprite_fetch_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sprite_fetch_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_fetch_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sprite_fetch_arbiter_pkg
// Shared constants and types for the sprite ROM fetch path.
//   SPRITE_DIM     : sprite edge length in pixels (square sprites)
//   SPRITE_PIXELS  : pixels per sprite, i.e. stride between sprite bases
//   NUM_SPRITES    : number of sprites stored in the ROM
//   STARVE_LIMIT   : back-to-back requester-0 wins tolerated while requester 1 waits
//   sprite_id_e    : ROM sprite layout (12 chess pieces followed by 10 digits)
//   rom_addr_t     : flat ROM word address
//   rgb_t          : 24-bit RGB pixel
// ---------------------------------------------------------------------------
package sprite_fetch_arbiter_pkg;

  localparam int SPRITE_DIM    = 60;
  localparam int SPRITE_PIXELS = SPRITE_DIM * SPRITE_DIM;
  localparam int NUM_SPRITES   = 22;
  localparam int STARVE_LIMIT  = 4;

  typedef enum logic [4:0] {
    PAWN_BLACK   = 5'd0,
    KNIGHT_BLACK = 5'd1,
    BISHOP_BLACK = 5'd2,
    ROOK_BLACK   = 5'd3,
    QUEEN_BLACK  = 5'd4,
    KING_BLACK   = 5'd5,
    PAWN_WHITE   = 5'd6,
    KNIGHT_WHITE = 5'd7,
    BISHOP_WHITE = 5'd8,
    ROOK_WHITE   = 5'd9,
    QUEEN_WHITE  = 5'd10,
    KING_WHITE   = 5'd11,
    DIGIT_0      = 5'd12,
    DIGIT_1      = 5'd13,
    DIGIT_2      = 5'd14,
    DIGIT_3      = 5'd15,
    DIGIT_4      = 5'd16,
    DIGIT_5      = 5'd17,
    DIGIT_6      = 5'd18,
    DIGIT_7      = 5'd19,
    DIGIT_8      = 5'd20,
    DIGIT_9      = 5'd21
  } sprite_id_e;

  typedef logic [16:0] rom_addr_t;
  typedef logic [23:0] rgb_t;

  // True when the (sprite,row,col) triple lies inside the ROM image.
  function automatic logic sprite_req_ok(input logic [4:0] sprite,
                                         input logic [5:0] row,
                                         input logic [5:0] col);
    return (sprite < 5'(NUM_SPRITES)) &&
           (row    < 6'(SPRITE_DIM))  &&
           (col    < 6'(SPRITE_DIM));
  endfunction

endpackage

// File: rtl/sprite_addr_calc.sv
// ---------------------------------------------------------------------------
// sprite_addr_calc
// Combinational translation of a sprite pixel coordinate into a flat ROM
// address: addr = sprite*3600 + row*60 + col. Out-of-range coordinates
// raise err and drive addr to zero so no bogus location is ever read.
//   sprite : sprite id (5b)
//   row    : pixel row inside the sprite (6b)
//   col    : pixel column inside the sprite (6b)
//   addr   : flat ROM address (17b), zero when err
//   err    : coordinate out of range
// ---------------------------------------------------------------------------
module sprite_addr_calc
  import sprite_fetch_arbiter_pkg::*;
(
  input  logic [4:0]  sprite,
  input  logic [5:0]  row,
  input  logic [5:0]  col,
  output logic [16:0] addr,
  output logic        err
);

  rom_addr_t sprite_w;
  rom_addr_t row_w;
  rom_addr_t base;
  rom_addr_t row_off;
  rom_addr_t sum;

  // Constant multiplies as shift-add: 3600 = 4096 - 512 + 16, 60 = 64 - 4.
  // The largest 5-bit id (31*3600 = 111600) still fits 17 bits, so the
  // arithmetic never wraps even before the range check masks it.
  always_comb begin
    sprite_w = {12'd0, sprite};
    row_w    = {11'd0, row};
    base     = (sprite_w << 12) - (sprite_w << 9) + (sprite_w << 4);
    row_off  = (row_w << 6) - (row_w << 2);
    sum      = base + row_off + {11'd0, col};
    err      = !sprite_req_ok(sprite, row, col);
    if (err) begin
      addr = 17'd0;
    end else begin
      addr = sum;
    end
  end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_fetch_arbiter
// Shares a single-port, 1-cycle-latency sprite ROM between the board
// renderer (requester 0) and the move-timer digit renderer (requester 1).
// One request is accepted per cycle; responses return in grant order two
// cycles after acceptance, tagged with the owning requester.
//   Clk        : system clock
//   Reset      : asynchronous active-high reset
//   req_valid  : [1:0] request strobes, bit i = requester i
//   req_ready  : [1:0] one-hot grant (combinational)
//   req_sprite : [9:0] sprite id, requester i in [i*5 +: 5]
//   req_row    : [11:0] pixel row, requester i in [i*6 +: 6]
//   req_col    : [11:0] pixel column, requester i in [i*6 +: 6]
//   rom_addr   : [16:0] registered ROM read address
//   rom_data   : [23:0] ROM output, valid one edge after rom_addr
//   rsp_valid  : response strobe, one per accepted request
//   rsp_id     : owning requester of the response
//   rsp_err    : request was out of range
//   rsp_data   : [23:0] pixel RGB, zero on error
// ---------------------------------------------------------------------------
module sprite_fetch_arbiter
  import sprite_fetch_arbiter_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [9:0]  req_sprite,
  input  logic [11:0] req_row,
  input  logic [11:0] req_col,
  output logic [16:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic        rsp_err,
  output logic [23:0] rsp_data
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [1:0]          grant;
  logic                sel;
  logic [4:0]          sel_sprite;
  logic [5:0]          sel_row;
  logic [5:0]          sel_col;
  rom_addr_t           calc_addr;
  logic                calc_err;

  logic [STARVE_W-1:0] starve_d, starve_q;
  rom_addr_t           rom_addr_d, rom_addr_q;
  logic                a_valid_d, a_valid_q;
  logic                a_id_d, a_id_q;
  logic                a_err_d, a_err_q;
  logic                rsp_valid_d, rsp_valid_q;
  logic                rsp_id_d, rsp_id_q;
  logic                rsp_err_d, rsp_err_q;

  // Fixed priority to requester 0, overridden for requester 1 once it has
  // watched STARVE_LIMIT consecutive requester-0 grants. Held off in reset.
  always_comb begin
    grant = 2'b00;
    if (Reset) begin
      grant = 2'b00;
    end else begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (starve_q == STARVE_MAX) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign sel       = grant[1];

  // Route the winning requester's coordinate into the single address calculator.
  always_comb begin
    sel_sprite = req_sprite[4:0];
    sel_row    = req_row[5:0];
    sel_col    = req_col[5:0];
    if (sel) begin
      sel_sprite = req_sprite[9:5];
      sel_row    = req_row[11:6];
      sel_col    = req_col[11:6];
    end else begin
      sel_sprite = req_sprite[4:0];
      sel_row    = req_row[5:0];
      sel_col    = req_col[5:0];
    end
  end

  sprite_addr_calc u_addr_calc (
    .sprite (sel_sprite),
    .row    (sel_row),
    .col    (sel_col),
    .addr   (calc_addr),
    .err    (calc_err)
  );

  // Starvation counter: counts requester-0 wins while requester 1 is waiting.
  always_comb begin
    starve_d = starve_q;
    if (grant[1] || !req_valid[1]) begin
      starve_d = '0;
    end else if (grant[0] && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + STARVE_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Stage A: ROM address plus the tag that travels alongside the read.
  // The address holds between grants so the ROM sees a stable input.
  always_comb begin
    rom_addr_d = rom_addr_q;
    a_valid_d  = |grant;
    a_id_d     = a_id_q;
    a_err_d    = a_err_q;
    if (|grant) begin
      rom_addr_d = calc_addr;
      a_id_d     = sel;
      a_err_d    = calc_err;
    end else begin
      rom_addr_d = rom_addr_q;
      a_id_d     = a_id_q;
      a_err_d    = a_err_q;
    end
  end

  // Stage B: tag aligned with the cycle in which the ROM presents the data.
  always_comb begin
    rsp_valid_d = a_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    if (a_valid_q) begin
      rsp_id_d  = a_id_q;
      rsp_err_d = a_err_q;
    end else begin
      rsp_id_d  = rsp_id_q;
      rsp_err_d = rsp_err_q;
    end
  end

  // State registers; reset drops anything in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      starve_q    <= '0;
      rom_addr_q  <= 17'd0;
      a_valid_q   <= 1'b0;
      a_id_q      <= 1'b0;
      a_err_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      rom_addr_q  <= rom_addr_d;
      a_valid_q   <= a_valid_d;
      a_id_q      <= a_id_d;
      a_err_q     <= a_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // The ROM output is already registered inside the ROM, so the data path
  // only needs masking on error rather than another flop stage.
  always_comb begin
    rsp_data = rom_data;
    if (rsp_err_q) begin
      rsp_data = 24'h000000;
    end else begin
      rsp_data = rom_data;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_fetch_arbiter
// Self-checking bench for sprite_fetch_arbiter with a behavioural ROM.
// Expected responses are queued when a grant is expected and compared when
// the response cycle comes round.
// ---------------------------------------------------------------------------
module tb_sprite_fetch_arbiter;

  logic        Clk;
  logic        Reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_sprite;
  logic [11:0] req_row;
  logic [11:0] req_col;
  logic [16:0] rom_addr;
  logic [23:0] rom_data;
  logic        rsp_valid;
  logic        rsp_id;
  logic        rsp_err;
  logic [23:0] rsp_data;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [23:0] data;
    logic [31:0] due;
  } exp_t;

  exp_t        sb[$];
  int          n_checks;
  int          n_errors;
  int          cyc;
  int          m_starve;
  logic [16:0] exp_addr;
  logic [1:0]  last_grant;
  logic [9:0]  gseq;

  sprite_fetch_arbiter dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sprite (req_sprite),
    .req_row    (req_row),
    .req_col    (req_col),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .rsp_data   (rsp_data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ROM image: an address-dependent pattern, non-zero at address 0.
  function automatic logic [23:0] rom_fn(input logic [16:0] a);
    return {a[7:0], a[16:1]} ^ 24'h3C5A96;
  endfunction

  // Behavioural single-port ROM with one cycle of read latency.
  always @(posedge Clk) rom_data <= rom_fn(rom_addr);

  // Posedge counter used to time-stamp expected responses.
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Response monitor: every cycle either the head of the queue is due or
  // the strobe must be low.
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset) begin
      if (sb.size() != 0 && sb[0].due == 32'(cyc)) begin
        e = sb.pop_front();
        check_val("rsp_valid", 32'(rsp_valid), 32'd1);
        check_val("rsp_id", 32'(rsp_id), 32'(e.id));
        check_val("rsp_err", 32'(rsp_err), 32'(e.err));
        check_val("rsp_data", 32'(rsp_data), 32'(e.data));
      end else begin
        check_val("rsp_spurious", 32'(rsp_valid), 32'd0);
      end
    end
  end

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic step(input logic [1:0] v,
                      input logic [4:0] s0, input logic [5:0] r0, input logic [5:0] c0,
                      input logic [4:0] s1, input logic [5:0] r1, input logic [5:0] c1);
    logic [1:0] g;
    logic [4:0] s;
    logic [5:0] r;
    logic [5:0] c;
    logic       e;
    exp_t       x;
    req_valid  = v;
    req_sprite = {s1, s0};
    req_row    = {r1, r0};
    req_col    = {c1, c0};
    case (v)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = (m_starve == 4) ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    @(negedge Clk);
    check_val("req_ready", 32'(req_ready), 32'(g));
    last_grant = g;
    if (g != 2'b00) begin
      s = g[1] ? s1 : s0;
      r = g[1] ? r1 : r0;
      c = g[1] ? c1 : c0;
      e = (s >= 5'd22) || (r >= 6'd60) || (c >= 6'd60);
      exp_addr = e ? 17'd0 : 17'(int'(s) * 3600 + int'(r) * 60 + int'(c));
      x.id   = g[1];
      x.err  = e;
      x.data = e ? 24'h000000 : rom_fn(exp_addr);
      x.due  = 32'(cyc + 2);
      sb.push_back(x);
    end
    if (g == 2'b10 || !v[1]) m_starve = 0;
    else if (g == 2'b01 && m_starve < 4) m_starve = m_starve + 1;
    @(posedge Clk);
    #1;
    check_val("rom_addr", 32'(rom_addr), 32'(exp_addr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 5'd0, 6'd0, 6'd0, 5'd0, 6'd0, 6'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    m_starve  = 0;
    exp_addr  = 17'd0;
    gseq      = 10'd0;
    Reset     = 1'b1;
    req_valid = 2'b00;
    req_sprite = 10'd0;
    req_row   = 12'd0;
    req_col   = 12'd0;
    #1;
    check_val("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("reset_req_ready", 32'(req_ready), 32'd0);
    check_val("reset_rom_addr", 32'(rom_addr), 32'd0);
    check_val("reset_rsp_id", 32'(rsp_id), 32'd0);
    check_val("reset_rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Idle after reset.
    idle(20);

    // Requester 0: first and last pixel of the ROM.
    step(2'b01, 5'd0, 6'd0, 6'd0, 5'd0, 6'd0, 6'd0);
    check_val("addr_first", 32'(rom_addr), 32'd0);
    step(2'b01, 5'd21, 6'd59, 6'd59, 5'd0, 6'd0, 6'd0);
    check_val("addr_last", 32'(rom_addr), 32'd79199);
    idle(3);

    // Requester 1 alone.
    step(2'b10, 5'd0, 6'd0, 6'd0, 5'd13, 6'd1, 6'd2);
    check_val("addr_req1", 32'(rom_addr), 32'd46862);
    idle(3);

    // Both requesting: requester 1 forced in every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      step(2'b11, 5'(i % 12), 6'(i * 5), 6'(i), 5'(12 + i), 6'(59 - i), 6'(i * 3));
      gseq[i] = last_grant[1];
    end
    check_val("grant_pattern", 32'(gseq), 32'h210);
    idle(3);

    // Out-of-range requests still produce (error) responses.
    step(2'b01, 5'd22, 6'd0, 6'd0, 5'd0, 6'd0, 6'd0);
    check_val("oor_sprite_addr", 32'(rom_addr), 32'd0);
    step(2'b01, 5'd0, 6'd60, 6'd0, 5'd0, 6'd0, 6'd0);
    step(2'b01, 5'd0, 6'd0, 6'd63, 5'd0, 6'd0, 6'd0);
    step(2'b10, 5'd0, 6'd0, 6'd0, 5'd31, 6'd5, 6'd5);
    step(2'b01, 5'd5, 6'd10, 6'd20, 5'd0, 6'd0, 6'd0);
    idle(3);

    // Reset with two reads in flight.
    step(2'b01, 5'd3, 6'd4, 6'd5, 5'd0, 6'd0, 6'd0);
    step(2'b01, 5'd7, 6'd8, 6'd9, 5'd0, 6'd0, 6'd0);
    req_valid = 2'b00;
    Reset     = 1'b1;
    #1;
    check_val("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("midreset_rom_addr", 32'(rom_addr), 32'd0);
    sb.delete();
    m_starve = 0;
    exp_addr = 17'd0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    idle(4);
    step(2'b10, 5'd0, 6'd0, 6'd0, 5'd20, 6'd30, 6'd40);
    idle(4);

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
